// File: rtl/memory_controller.sv
// memory_controller: serializes LSB loads/stores and IF word fetches onto a byte-wide registered-read RAM bus.
// Define MEMCTRL_IO_STALL_EN to hold stores to the IO window while io_buffer_full is high.
module memory_controller #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] IO_ADDR_LO = 32'h00030000,
   parameter logic [ADDR_WIDTH-1:0] IO_ADDR_HI = 32'h00030007
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  lsb_signal,
   input  logic                  lsb_wr,
   input  logic [1:0]            lsb_len,
   input  logic [ADDR_WIDTH-1:0] lsb_addr,
   input  logic [31:0]           lsb_din,
   output logic [31:0]           lsb_dout,
   output logic                  lsb_done,
   input  logic                  if_signal,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic [31:0]           if_dout,
   output logic                  if_done,
   input  logic [7:0]            ram_din,
   output logic [7:0]            ram_dout,
   output logic [ADDR_WIDTH-1:0] ram_a,
   output logic                  ram_wr,
   input  logic                  io_buffer_full
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;
   state_e                state_q;
   logic [2:0]            cnt_q;
   logic [1:0]            last_q, idx, nidx;
   logic                  if_own_q, lsb_done_q, if_done_q, ram_wr_q, stall;
   logic [31:0]           din_q, buf_q, buf_d, lsb_dout_q, if_dout_q;
   logic [7:0]            ram_dout_q;
   logic [ADDR_WIDTH-1:0] ram_a_q;
   // in READ, the byte arriving on ram_din belongs to the address issued one cycle earlier
   assign idx  = cnt_q[1:0] - 2'd1;
   assign nidx = cnt_q[1:0] + 2'd1;
   always_comb begin
      buf_d = buf_q;
      buf_d[{idx, 3'b000} +: 8] = ram_din;
   end
`ifdef MEMCTRL_IO_STALL_EN
   assign stall = state_q == WRITE && ram_a_q >= IO_ADDR_LO && ram_a_q <= IO_ADDR_HI && io_buffer_full;
`else
   logic unused_io;
   assign unused_io = ^{io_buffer_full, IO_ADDR_LO, IO_ADDR_HI};
   assign stall = 1'b0;
`endif
   assign lsb_dout = lsb_dout_q;
   assign lsb_done = lsb_done_q;
   assign if_dout  = if_dout_q;
   assign if_done  = if_done_q;
   assign ram_dout = ram_dout_q;
   assign ram_a    = ram_a_q;
   assign ram_wr   = ram_wr_q & ~stall;
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         last_q     <= '0;
         if_own_q   <= 1'b0;
         din_q      <= '0;
         buf_q      <= '0;
         lsb_dout_q <= '0;
         if_dout_q  <= '0;
         lsb_done_q <= 1'b0;
         if_done_q  <= 1'b0;
         ram_a_q    <= '0;
         ram_dout_q <= '0;
         ram_wr_q   <= 1'b0;
      end else if (rdy_in) begin
         lsb_done_q <= 1'b0;
         if_done_q  <= 1'b0;
         case (state_q)
            IDLE: if (lsb_signal || if_signal) begin
               state_q    <= lsb_signal && lsb_wr ? WRITE : READ;
               if_own_q   <= ~lsb_signal;
               last_q     <= !lsb_signal ? 2'd3 : lsb_len == 2'b00 ? 2'd0 : lsb_len == 2'b01 ? 2'd1 : 2'd3;
               ram_a_q    <= lsb_signal ? lsb_addr : if_addr;
               din_q      <= lsb_din;
               ram_dout_q <= lsb_din[7:0];
               ram_wr_q   <= lsb_signal && lsb_wr;
               cnt_q      <= '0;
               buf_q      <= '0;
            end
            READ: begin
               cnt_q <= cnt_q + 3'd1;
               if (cnt_q != 3'd0) buf_q <= buf_d;
               if (cnt_q < {1'b0, last_q}) ram_a_q <= ram_a_q + ADDR_WIDTH'(1);
               if (cnt_q == {1'b0, last_q} + 3'd1) begin
                  state_q <= DONE;
                  if (if_own_q) begin
                     if_done_q <= 1'b1;
                     if_dout_q <= buf_d;
                  end else begin
                     lsb_done_q <= 1'b1;
                     lsb_dout_q <= buf_d;
                  end
               end
            end
            WRITE: if (!stall) begin
               if (cnt_q[1:0] == last_q) begin
                  state_q    <= DONE;
                  ram_wr_q   <= 1'b0;
                  lsb_done_q <= 1'b1;
               end else begin
                  cnt_q      <= cnt_q + 3'd1;
                  ram_a_q    <= ram_a_q + ADDR_WIDTH'(1);
                  ram_dout_q <= din_q[{nidx, 3'b000} +: 8];
               end
            end
            DONE: state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_memory_controller.sv
// tb_memory_controller: randomized and directed checks of memory_controller against a byte-array RAM
// and a behavioural model of load/store results, write sequences and latencies.
module tb_memory_controller;
   logic        clk_in = 1'b0;
   logic        rst_in, rdy_in, lsb_signal, lsb_wr, if_signal, ram_wr, lsb_done, if_done, io_buffer_full;
   logic [1:0]  lsb_len;
   logic [31:0] lsb_addr, lsb_din, lsb_dout, if_addr, if_dout, ram_a;
   logic [7:0]  ram_din, ram_dout;
   logic        bd_we;
   logic [15:0] bd_a;
   logic [7:0]  bd_d;
   logic [7:0]  mem [0:65535];
   logic [7:0]  ref_mem [0:63];
   logic [39:0] wq [$];
   int          pass_cnt = 0, total_cnt = 0;

   always #5 clk_in = ~clk_in;

   memory_controller dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      .lsb_signal(lsb_signal), .lsb_wr(lsb_wr), .lsb_len(lsb_len), .lsb_addr(lsb_addr),
      .lsb_din(lsb_din), .lsb_dout(lsb_dout), .lsb_done(lsb_done),
      .if_signal(if_signal), .if_addr(if_addr), .if_dout(if_dout), .if_done(if_done),
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
      .io_buffer_full(io_buffer_full)
   );

   // byte RAM aliased on the low 16 address bits; stalled by rdy_in like the real part
   always @(posedge clk_in) begin
      if (bd_we) mem[bd_a] <= bd_d;
      else if (rdy_in) begin
         if (ram_wr) mem[ram_a[15:0]] <= ram_dout;
         ram_din <= mem[ram_a[15:0]];
      end
   end

   always @(posedge clk_in) if (rdy_in && ram_wr && !bd_we) wq.push_back({ram_a, ram_dout});

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic poke(input logic [31:0] a, input logic [7:0] d);
      bd_a = a[15:0];
      bd_d = d;
      bd_we = 1'b1;
      tick();
      bd_we = 1'b0;
   endtask

   task automatic access(input logic is_if, input logic wr, input logic [1:0] len, input logic [31:0] addr,
                         input logic [31:0] din, output int lat, output logic [31:0] dout, output logic after);
      if (is_if) begin
         if_addr = addr;
         if_signal = 1'b1;
      end else begin
         lsb_wr = wr;
         lsb_len = len;
         lsb_addr = addr;
         lsb_din = din;
         lsb_signal = 1'b1;
      end
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!(is_if ? if_done : lsb_done) && lat < 50);
      dout = is_if ? if_dout : lsb_dout;
      lsb_signal = 1'b0;
      if_signal = 1'b0;
      tick();
      after = lsb_done | if_done;
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      tick();
      tick();
      total_cnt++;
      if ({lsb_done, if_done, lsb_dout, if_dout, ram_a, ram_dout, ram_wr} !== 107'd0)
         $display("FAIL reset_outputs: got done=%b/%b lsb_dout=%h if_dout=%h ram_a=%h ram_dout=%h ram_wr=%b, want all 0",
                  lsb_done, if_done, lsb_dout, if_dout, ram_a, ram_dout, ram_wr);
      else pass_cnt++;
      rst_in = 1'b0;
      tick();
   endtask

   task automatic test_word_load();
      int lat;
      logic [31:0] d;
      logic a;
      poke(32'h1000, 8'h78);
      poke(32'h1001, 8'h56);
      poke(32'h1002, 8'h34);
      poke(32'h1003, 8'h12);
      wq.delete();
      access(1'b0, 1'b0, 2'b10, 32'h1000, 32'h0, lat, d, a);
      total_cnt++;
      if (lat !== 6) $display("FAIL word_load_latency: got %0d want 6", lat); else pass_cnt++;
      total_cnt++;
      if (d !== 32'h12345678) $display("FAIL word_load_data: got %h want 12345678", d); else pass_cnt++;
      total_cnt++;
      if (wq.size() !== 0) $display("FAIL word_load_no_write: got %0d writes want 0", wq.size()); else pass_cnt++;
      total_cnt++;
      if (a !== 1'b0) $display("FAIL word_load_pulse: done still %b after one cycle want 0", a); else pass_cnt++;
   endtask

   task automatic test_byte_store();
      int lat;
      logic [31:0] d;
      logic a;
      poke(32'h2004, 8'h5A);
      wq.delete();
      access(1'b0, 1'b1, 2'b00, 32'h2003, 32'hAABBCCDD, lat, d, a);
      total_cnt++;
      if (lat !== 2) $display("FAIL byte_store_latency: got %0d want 2", lat); else pass_cnt++;
      total_cnt++;
      if (wq.size() !== 1 || wq[0] !== {32'h2003, 8'hDD})
         $display("FAIL byte_store_write: got %0d writes first=%h want 1 write 00002003dd", wq.size(), wq.size() ? wq[0] : 40'h0);
      else pass_cnt++;
      total_cnt++;
      if (mem[16'h2004] !== 8'h5A) $display("FAIL byte_store_neighbour: got %h want 5a", mem[16'h2004]); else pass_cnt++;
      total_cnt++;
      if (d !== 32'h12345678) $display("FAIL byte_store_dout_kept: got %h want 12345678", d); else pass_cnt++;
   endtask

   task automatic test_arbitration();
      int lt, it;
      logic both;
      logic [31:0] ld, id;
      poke(32'h0, 8'h13);
      poke(32'h1, 8'h00);
      poke(32'h2, 8'h00);
      poke(32'h3, 8'h00);
      poke(32'h10, 8'hEF);
      poke(32'h11, 8'hBE);
      lsb_wr = 1'b0;
      lsb_len = 2'b01;
      lsb_addr = 32'h10;
      if_addr = 32'h0;
      lsb_signal = 1'b1;
      if_signal = 1'b1;
      lt = 0;
      it = 0;
      both = 1'b0;
      ld = '0;
      id = '0;
      for (int t = 1; t <= 40 && it == 0; t++) begin
         tick();
         if (lsb_done && if_done) both = 1'b1;
         if (lsb_done) begin
            lt = t;
            ld = lsb_dout;
            lsb_signal = 1'b0;
         end
         if (if_done) begin
            it = t;
            id = if_dout;
            if_signal = 1'b0;
         end
      end
      lsb_signal = 1'b0;
      if_signal = 1'b0;
      tick();
      total_cnt++;
      if (lt !== 4 || it !== 11) $display("FAIL arb_order: lsb_done at %0d if_done at %0d want 4 and 11", lt, it); else pass_cnt++;
      total_cnt++;
      if (both !== 1'b0) $display("FAIL arb_same_cycle: got %b want 0", both); else pass_cnt++;
      total_cnt++;
      if (ld !== 32'h0000BEEF) $display("FAIL arb_lsb_data: got %h want 0000beef", ld); else pass_cnt++;
      total_cnt++;
      if (id !== 32'h00000013) $display("FAIL arb_if_data: got %h want 00000013", id); else pass_cnt++;
   endtask

   task automatic test_wrap();
      int lat;
      logic [31:0] d, a_exp;
      logic a;
      logic [31:0] din;
      din = 32'hCAFEF00D;
      wq.delete();
      access(1'b0, 1'b1, 2'b10, 32'hFFFFFFFE, din, lat, d, a);
      total_cnt++;
      if (lat !== 5 || wq.size() !== 4) $display("FAIL wrap_shape: got latency %0d writes %0d want 5 and 4", lat, wq.size()); else pass_cnt++;
      for (int k = 0; k < 4 && k < wq.size(); k++) begin
         a_exp = 32'hFFFFFFFE + k;
         total_cnt++;
         if (wq[k] !== {a_exp, din[8*k +: 8]}) $display("FAIL wrap_byte%0d: got %h want %h", k, wq[k], {a_exp, din[8*k +: 8]});
         else pass_cnt++;
      end
   endtask

   task automatic test_freeze();
      int lat;
      poke(32'h3000, 8'h01);
      poke(32'h3001, 8'h02);
      poke(32'h3002, 8'h03);
      poke(32'h3003, 8'h04);
      lsb_wr = 1'b0;
      lsb_len = 2'b10;
      lsb_addr = 32'h3000;
      lsb_signal = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
         if (lat == 2) rdy_in = 1'b0;
         if (lat == 5) rdy_in = 1'b1;
      end while (!lsb_done && lat < 50);
      total_cnt++;
      if (lat !== 9) $display("FAIL freeze_latency: got %0d want 9", lat); else pass_cnt++;
      total_cnt++;
      if (lsb_dout !== 32'h04030201) $display("FAIL freeze_data: got %h want 04030201", lsb_dout); else pass_cnt++;
      lsb_signal = 1'b0;
      tick();
   endtask

   task automatic test_reset_mid_write();
      int lat, dones;
      logic [31:0] d;
      logic a;
      for (int k = 0; k < 4; k++) poke(32'h4000 + k, 8'h00);
      wq.delete();
      lsb_wr = 1'b1;
      lsb_len = 2'b10;
      lsb_addr = 32'h4000;
      lsb_din = 32'h11223344;
      lsb_signal = 1'b1;
      tick();
      tick();
      rst_in = 1'b1;
      lsb_signal = 1'b0;
      tick();
      total_cnt++;
      if (ram_wr !== 1'b0) $display("FAIL rst_write_stops: ram_wr got %b want 0", ram_wr); else pass_cnt++;
      rst_in = 1'b0;
      dones = 0;
      for (int t = 0; t < 6; t++) begin
         if (lsb_done || ram_wr) dones++;
         tick();
      end
      total_cnt++;
      if (dones !== 0 || wq.size() !== 2) $display("FAIL rst_abandon: got %0d done/write cycles, %0d writes want 0 and 2", dones, wq.size()); else pass_cnt++;
      access(1'b0, 1'b0, 2'b10, 32'h4000, 32'h0, lat, d, a);
      total_cnt++;
      if (lat !== 6 || d !== 32'h00003344) $display("FAIL rst_followup_load: got latency %0d data %h want 6 00003344", lat, d); else pass_cnt++;
   endtask

   task automatic test_io_store();
      int lat, exp_lat;
      wq.delete();
      io_buffer_full = 1'b1;
      lsb_wr = 1'b1;
      lsb_len = 2'b00;
      lsb_addr = 32'h00030000;
      lsb_din = 32'h0000005A;
      lsb_signal = 1'b1;
      lat = 0;
      do begin
         tick();
         lat++;
         if (lat == 5) io_buffer_full = 1'b0;
      end while (!lsb_done && lat < 50);
      lsb_signal = 1'b0;
      io_buffer_full = 1'b0;
      tick();
`ifdef MEMCTRL_IO_STALL_EN
      exp_lat = 6;
`else
      exp_lat = 2;
`endif
      total_cnt++;
      if (lat !== exp_lat) $display("FAIL io_store_latency: got %0d want %0d", lat, exp_lat); else pass_cnt++;
      total_cnt++;
      if (wq.size() !== 1 || wq[0] !== {32'h00030000, 8'h5A})
         $display("FAIL io_store_write: got %0d writes first=%h want 1 write 000300005a", wq.size(), wq.size() ? wq[0] : 40'h0);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int lat, n, exp_lat;
      logic is_if, wr, a;
      logic [1:0] len;
      logic [31:0] addr, din, d, prev, exp;
      logic [7:0] b;
      for (int j = 0; j < 64; j++) begin
         b = 8'($urandom);
         ref_mem[j] = b;
         poke(32'h5000 + j, b);
      end
      for (int i = 0; i < 40; i++) begin
         is_if = $urandom_range(0, 3) == 0;
         wr = !is_if && $urandom_range(0, 1) == 1;
         len = is_if ? 2'b10 : 2'($urandom_range(0, 3));
         n = len == 2'b00 ? 1 : len == 2'b01 ? 2 : 4;
         addr = 32'h5000 + $urandom_range(0, 60);
         din = $urandom;
         prev = lsb_dout;
         wq.delete();
         access(is_if, wr, len, addr, din, lat, d, a);
         exp_lat = wr ? n + 1 : n + 2;
         total_cnt++;
         if (lat !== exp_lat) $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, exp_lat); else pass_cnt++;
         total_cnt++;
         if (a !== 1'b0) $display("FAIL rnd%0d_pulse: done still %b want 0", i, a); else pass_cnt++;
         if (wr) begin
            total_cnt++;
            if (wq.size() !== n || d !== prev) $display("FAIL rnd%0d_store: got %0d writes dout %h want %0d writes dout %h", i, wq.size(), d, n, prev);
            else pass_cnt++;
            for (int k = 0; k < n; k++) begin
               b = 8'(din >> (8 * k));
               ref_mem[addr - 32'h5000 + k] = b;
               if (k < wq.size()) begin
                  total_cnt++;
                  if (wq[k] !== {addr + k, b}) $display("FAIL rnd%0d_wbyte%0d: got %h want %h", i, k, wq[k], {addr + k, b});
                  else pass_cnt++;
               end
            end
         end else begin
            exp = '0;
            for (int k = 0; k < n; k++) exp = exp | (32'(ref_mem[addr - 32'h5000 + k]) << (8 * k));
            total_cnt++;
            if (d !== exp || wq.size() !== 0) $display("FAIL rnd%0d_load: got %h with %0d writes want %h with 0", i, d, wq.size(), exp);
            else pass_cnt++;
         end
      end
   endtask

   initial begin
      rst_in = 1'b1;
      rdy_in = 1'b1;
      lsb_signal = 1'b0;
      lsb_wr = 1'b0;
      lsb_len = 2'b00;
      lsb_addr = '0;
      lsb_din = '0;
      if_signal = 1'b0;
      if_addr = '0;
      io_buffer_full = 1'b0;
      bd_we = 1'b0;
      bd_a = '0;
      bd_d = '0;
      test_reset();
      test_word_load();
      test_byte_store();
      test_arbitration();
      test_wrap();
      test_freeze();
      test_reset_mid_write();
      test_io_store();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
